writeback_stage: RTL and testbench

//   Y86-64 pipeline stage directly downstream of the memory stage: holds the M->W

---
 rtl/y86_pkg.sv | 35 +++
 rtl/regfile_15x64.sv | 53 +++++
 rtl/writeback_stage.sv | 131 +++++++++++++
 tb/tb_writeback_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings: icodes, register IDs, status codes,
//               and the field values of a pipeline nop bubble.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] c_icode_halt   = 4'h0;
    localparam logic [3:0] c_icode_nop    = 4'h1;
    localparam logic [3:0] c_icode_rrmovq = 4'h2;
    localparam logic [3:0] c_icode_irmovq = 4'h3;
    localparam logic [3:0] c_icode_rmmovq = 4'h4;
    localparam logic [3:0] c_icode_mrmovq = 4'h5;
    localparam logic [3:0] c_icode_opq    = 4'h6;
    localparam logic [3:0] c_icode_jxx    = 4'h7;
    localparam logic [3:0] c_icode_call   = 4'h8;
    localparam logic [3:0] c_icode_ret    = 4'h9;
    localparam logic [3:0] c_icode_pushq  = 4'hA;
    localparam logic [3:0] c_icode_popq   = 4'hB;

    localparam logic [3:0] c_rnone = 4'hF;

    localparam logic [2:0] c_stat_aok = 3'd1;
    localparam logic [2:0] c_stat_hlt = 3'd2;
    localparam logic [2:0] c_stat_adr = 3'd3;
    localparam logic [2:0] c_stat_ins = 3'd4;

    localparam logic [3:0] c_bubble_icode = c_icode_nop;
    localparam logic [2:0] c_bubble_stat  = c_stat_aok;
    localparam logic [3:0] c_bubble_dst   = c_rnone;

endpackage
`default_nettype wire

// File: rtl/regfile_15x64.sv
`default_nettype none
// ============================================================================
// Module      : regfile_15x64
// Description : Architectural register file, two combinational read ports and
//               two synchronous write ports; port M wins on address conflict.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_15x64
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we_e,
    input  logic [3:0]        i_addr_e,
    input  logic [DATA_W-1:0] i_data_e,
    input  logic              i_we_m,
    input  logic [3:0]        i_addr_m,
    input  logic [DATA_W-1:0] i_data_m,
    input  logic [3:0]        i_addr_a,
    input  logic [3:0]        i_addr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                r_regs[i] <= '0;
            end else if (i_we_m && (i_addr_m == 4'(i))) begin
                r_regs[i] <= i_data_m;
            end else if (i_we_e && (i_addr_e == 4'(i))) begin
                r_regs[i] <= i_data_e;
            end
        end
    end

    // RNONE never matches an index, so it reads as zero.
    always_comb begin
        o_rdata_a = '0;
        o_rdata_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i_addr_a == 4'(i)) o_rdata_a = r_regs[i];
            if (i_addr_b == 4'(i)) o_rdata_b = r_regs[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Y86-64 write-back stage: M->W pipeline register, register file
//               commit, and sticky program-status tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              W_stall,
    input  logic              W_bubble,
    input  logic [2:0]        m_stat,
    input  logic [3:0]        m_icode,
    input  logic [DATA_W-1:0] m_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        m_dstE,
    input  logic [3:0]        m_dstM,
    input  logic              data_memory_error,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] d_rvalA,
    output logic [DATA_W-1:0] d_rvalB,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [2:0]        W_stat,
    output logic [2:0]        Stat,
    output logic              halted
);

    localparam logic [0:0] c_st_run    = 1'b0;
    localparam logic [0:0] c_st_halted = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic [2:0]        r_stat;
    logic [2:0]        w_next_stat;
    logic              w_commit;

    logic [3:0]        r_w_icode;
    logic [DATA_W-1:0] r_w_val_e;
    logic [DATA_W-1:0] r_w_val_m;
    logic [3:0]        r_w_dst_e;
    logic [3:0]        r_w_dst_m;
    logic [2:0]        r_w_stat;

    always_ff @(posedge clk) begin
        if (reset || (W_bubble && !W_stall)) begin
            r_w_icode <= c_bubble_icode;
            r_w_val_e <= '0;
            r_w_val_m <= '0;
            r_w_dst_e <= c_bubble_dst;
            r_w_dst_m <= c_bubble_dst;
            r_w_stat  <= c_bubble_stat;
        end else if (!W_stall) begin
            r_w_icode <= m_icode;
            r_w_val_e <= m_valE;
            r_w_val_m <= m_valM;
            r_w_dst_e <= m_dstE;
            r_w_dst_m <= m_dstM;
            r_w_stat  <= data_memory_error ? c_stat_adr : m_stat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_run;
            r_stat  <= c_stat_aok;
        end else begin
            r_state <= w_next_state;
            r_stat  <= w_next_stat;
        end
    end

    // The first faulting W entry both latches its code and is itself blocked.
    always_comb begin
        w_next_state = r_state;
        w_next_stat  = r_stat;
        w_commit     = 1'b0;
        case (r_state)
            c_st_run: begin
                if (r_w_stat != c_stat_aok) begin
                    w_next_state = c_st_halted;
                    w_next_stat  = r_w_stat;
                end else begin
                    w_commit = 1'b1;
                end
            end
            default: begin
                w_next_state = c_st_halted;
            end
        endcase
    end

    regfile_15x64 #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (reset),
        .i_we_e    (w_commit && (r_w_dst_e != c_rnone)),
        .i_addr_e  (r_w_dst_e),
        .i_data_e  (r_w_val_e),
        .i_we_m    (w_commit && (r_w_dst_m != c_rnone)),
        .i_addr_m  (r_w_dst_m),
        .i_data_m  (r_w_val_m),
        .i_addr_a  (d_srcA),
        .i_addr_b  (d_srcB),
        .o_rdata_a (d_rvalA),
        .o_rdata_b (d_rvalB)
    );

    assign W_icode = r_w_icode;
    assign W_valE  = r_w_val_e;
    assign W_valM  = r_w_val_m;
    assign W_dstE  = r_w_dst_e;
    assign W_dstM  = r_w_dst_m;
    assign W_stat  = r_w_stat;
    assign Stat    = r_stat;
    assign halted  = (r_state == c_st_halted);

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        W_stall;
    logic        W_bubble;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic        data_memory_error;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [2:0]  W_stat;
    logic [2:0]  Stat;
    logic        halted;

    int n_total;
    int n_bad;

    writeback_stage u_dut (
        .clk               (clk),
        .reset             (reset),
        .W_stall           (W_stall),
        .W_bubble          (W_bubble),
        .m_stat            (m_stat),
        .m_icode           (m_icode),
        .m_valE            (m_valE),
        .m_valM            (m_valM),
        .m_dstE            (m_dstE),
        .m_dstM            (m_dstM),
        .data_memory_error (data_memory_error),
        .d_srcA            (d_srcA),
        .d_srcB            (d_srcB),
        .d_rvalA           (d_rvalA),
        .d_rvalB           (d_rvalB),
        .W_icode           (W_icode),
        .W_valE            (W_valE),
        .W_valM            (W_valM),
        .W_dstE            (W_dstE),
        .W_dstM            (W_dstM),
        .W_stat            (W_stat),
        .Stat              (Stat),
        .halted            (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        m_stat  = st;
        m_icode = ic;
        m_valE  = ve;
        m_valM  = vm;
        m_dstE  = de;
        m_dstM  = dm;
    endtask

    task automatic drive_nop();
        drive(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    task automatic read_a(input logic [3:0] r, input string tag, input logic [63:0] exp);
        d_srcA = r;
        #1;
        check(tag, d_rvalA, exp);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b0;
        W_stall = 1'b0;
        W_bubble = 1'b0;
        data_memory_error = 1'b0;
        d_srcA = 4'hF;
        d_srcB = 4'hF;
        drive(3'd1, 4'h6, 64'hDEAD, 64'hBEEF, 4'h7, 4'h8);

        // T1: reset, with stall asserted to show reset dominates
        reset = 1'b1;
        W_stall = 1'b1;
        tick();
        reset = 1'b0;
        W_stall = 1'b0;
        drive_nop();
        for (int r = 0; r < 16; r++) begin
            read_a(4'(r), "t1_reg_zero", 64'd0);
        end
        check("t1_w_icode", 64'(W_icode), 64'd1);
        check("t1_w_dste", 64'(W_dstE), 64'hF);
        check("t1_w_dstm", 64'(W_dstM), 64'hF);
        check("t1_stat", 64'(Stat), 64'd1);
        check("t1_halted", 64'(halted), 64'd0);

        // T2: dual write, one cycle of commit latency
        drive(3'd1, 4'h5, 64'd50, 64'd20, 4'h0, 4'h3);
        tick();
        drive_nop();
        check("t2_w_vale", W_valE, 64'd50);
        read_a(4'h0, "t2_pre_commit", 64'd0);
        tick();
        d_srcB = 4'h3;
        read_a(4'h0, "t2_reg0", 64'd50);
        check("t2_reg3", d_rvalB, 64'd20);
        d_srcB = 4'hF;
        #1;
        check("t2_rnone_b", d_rvalB, 64'd0);

        // T3: dstE == dstM, valM wins
        drive(3'd1, 4'hB, 64'd8, 64'hFFFF_FFFF_FFFF_FFCE, 4'h4, 4'h4);
        tick();
        drive_nop();
        tick();
        read_a(4'h4, "t3_conflict", 64'hFFFF_FFFF_FFFF_FFCE);

        // T4: stall holds W, bubble loads nop
        drive(3'd1, 4'h3, 64'd111, 64'd0, 4'h5, 4'hF);
        tick();
        W_stall = 1'b1;
        drive(3'd1, 4'h3, 64'd222, 64'd0, 4'h6, 4'hF);
        tick();
        check("t4_stall_vale", W_valE, 64'd111);
        check("t4_stall_dste", 64'(W_dstE), 64'h5);
        read_a(4'h5, "t4_reg5", 64'd111);
        W_bubble = 1'b1;
        tick();
        check("t4_stall_over_bubble", 64'(W_dstE), 64'h5);
        W_stall = 1'b0;
        tick();
        W_bubble = 1'b0;
        drive_nop();
        check("t4_bubble_icode", 64'(W_icode), 64'd1);
        check("t4_bubble_dste", 64'(W_dstE), 64'hF);
        tick();
        read_a(4'h6, "t4_reg6_untouched", 64'd0);

        // T5: memory fault overrides status and freezes state
        data_memory_error = 1'b1;
        drive(3'd1, 4'h5, 64'd0, 64'd777, 4'hF, 4'h2);
        tick();
        data_memory_error = 1'b0;
        drive(3'd1, 4'h3, 64'd999, 64'd0, 4'h2, 4'hF);
        check("t5_w_stat", 64'(W_stat), 64'd3);
        check("t5_stat_pre", 64'(Stat), 64'd1);
        tick();
        drive(3'd2, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF);
        check("t5_stat", 64'(Stat), 64'd3);
        check("t5_halted", 64'(halted), 64'd1);
        tick();
        drive_nop();
        tick();
        tick();
        read_a(4'h2, "t5_reg2_frozen", 64'd0);
        check("t5_stat_sticky", 64'(Stat), 64'd3);

        // T6: halt, then reset clears everything
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_a(4'h0, "t6_reg0_clear", 64'd0);
        drive(3'd2, 4'h0, 64'd0, 64'd0, 4'hF, 4'hF);
        tick();
        drive_nop();
        check("t6_w_stat_hlt", 64'(W_stat), 64'd2);
        tick();
        check("t6_halted", 64'(halted), 64'd1);
        check("t6_stat_hlt", 64'(Stat), 64'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_stat_reset", 64'(Stat), 64'd1);
        check("t6_halted_reset", 64'(halted), 64'd0);
        read_a(4'h4, "t6_reg4_clear", 64'd0);

        // post-reset write works again
        drive(3'd1, 4'h3, 64'd42, 64'd0, 4'hE, 4'hF);
        tick();
        drive_nop();
        tick();
        read_a(4'hE, "t6_reg14_after", 64'd42);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
